counter_sched: RTL

- Controller and event scheduler for a bank of parallel wrap-around counters.
- Holds per-channel limit and enable configuration, and sequences run, pause and clear through a command FSM.
- Drives the counter bank and reports wrap events to downstream logic through one valid/ready event port, using round-robin arbitration across channels.

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/counter_sched_rr_arbiter.sv | 29 ++
 rtl/counter_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared command and FSM state encodings for the counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_CLR
  } state_e;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    // Scan from the farthest offset back towards ptr so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((32'(ptr) + 32'(k)) % 32'(N));
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Command FSM, per-channel wrap-around counter bank and round-robin wrap-event port.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int WIDTH     = 4,
  parameter  int DEF_LIMIT = 10,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_limit,
  input  logic                    cfg_en,
  output logic                    cfg_err,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd,
  output logic                    cmd_ready,
  output logic [NUM_CH*WIDTH-1:0] cnt_value,
  output logic                    running,
  output logic                    evt_valid,
  output logic [CH_W-1:0]         evt_ch,
  input  logic                    evt_ready,
  output logic [NUM_CH-1:0]       evt_ovf
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q   [NUM_CH];
  logic [WIDTH-1:0]  cnt_d   [NUM_CH];
  logic [WIDTH-1:0]  limit_q [NUM_CH];
  logic [WIDTH-1:0]  limit_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, pending_q, pending_d, ovf_q, ovf_d, wrap;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d, ptr_q, ptr_d, grant_idx;
  logic              evt_valid_q, evt_valid_d, cfg_err_q, cfg_err_d, running_q, running_d;
  logic              grant_valid, cmd_fire, clr_now, run, out_free, cfg_ok, take;
  cmd_e              cmd_in;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req         (pending_q),
    .ptr         (ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign cmd_ready = (state_q != S_CLR);
  assign running   = running_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_ovf   = ovf_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    cmd_in   = cmd_e'(cmd);
    cmd_fire = cmd_valid && cmd_ready;
    run      = (state_q == S_RUN);
    // Clearing acts on the accepting edge and again while sitting in CLR.
    clr_now  = (cmd_fire && cmd_in == CMD_CLEAR) || (state_q == S_CLR);

    state_d = state_q;
    if (state_q == S_CLR) begin
      state_d = S_IDLE;
    end else if (cmd_fire) begin
      unique case (cmd_in)
        CMD_START: state_d = S_RUN;
        CMD_STOP:  if (state_q == S_RUN) state_d = S_PAUSE;
        CMD_CLEAR: state_d = S_CLR;
        default:   ;
      endcase
    end
    running_d = (state_d == S_RUN);

    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      wrap[i]  = 1'b0;
      if (run && en_q[i]) begin
        if (cnt_q[i] >= limit_q[i]) begin
          cnt_d[i] = '0;
          wrap[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (clr_now) cnt_d[i] = '0;
    end

    limit_d   = limit_q;
    en_d      = en_q;
    cfg_ok    = 32'(cfg_ch) < 32'(NUM_CH);
    cfg_err_d = cfg_we && (run || !cfg_ok);
    if (cfg_we && !run && cfg_ok) begin
      limit_d[cfg_ch] = cfg_limit;
      en_d[cfg_ch]    = cfg_en;
    end

    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    ovf_d       = ovf_q;
    out_free    = !evt_valid_q || evt_ready;
    take        = out_free && grant_valid;
    if (out_free) evt_valid_d = grant_valid;
    if (take) begin
      evt_ch_d             = grant_idx;
      ptr_d                = CH_W'((32'(grant_idx) + 32'd1) % 32'(NUM_CH));
      pending_d[grant_idx] = 1'b0;
    end
    // A wrap landing on a bit granted this cycle re-arms it instead of overflowing.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrap[i]) begin
        if (pending_d[i]) ovf_d[i] = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
    if (clr_now) begin
      pending_d   = '0;
      ovf_d       = '0;
      evt_valid_d = 1'b0;
    end

    for (int i = 0; i < NUM_CH; i++) cnt_value[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      running_q   <= 1'b0;
      en_q        <= '1;
      pending_q   <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ptr_q       <= '0;
      cfg_err_q   <= 1'b0;
      // NOTE: counters and limits are small flop arrays, not RAM, so they take a reset value.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= '0;
        limit_q[i] <= WIDTH'(DEF_LIMIT);
      end
    end else begin
      // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
      state_q     <= state_d;
      running_q   <= running_d;
      en_q        <= en_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ptr_q       <= ptr_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
    end
  end

endmodule
